// File: rtl/spi_peripheral.sv
// SPI mode-0 target holding the five PWM configuration registers written by 16-bit frames.
// Optional register readback on cipo is built when SPI_READBACK_EN is defined.
module spi_peripheral #(
   parameter int         SYNC_STAGES = 2,
   parameter logic [6:0] MAX_ADDR    = 7'h04
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sclk,
   input  logic       copi,
   input  logic       ncs,
   output logic       cipo,
   output logic [7:0] en_reg_out_7_0,
   output logic [7:0] en_reg_out_15_8,
   output logic [7:0] en_reg_pwm_7_0,
   output logic [7:0] en_reg_pwm_15_8,
   output logic [7:0] pwm_duty_cycle
);

   logic [SYNC_STAGES-1:0] sclk_sync, ncs_sync, copi_sync;
   logic                   sclk_q, ncs_q;
   logic                   sclk_s, ncs_s, copi_s;
   logic                   sclk_rise, ncs_rise, ncs_fall;
   logic [15:0]            shift_reg;
   logic [4:0]             bit_cnt;
   logic                   wr_pend;

   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign ncs_s     = ncs_sync[SYNC_STAGES-1];
   assign copi_s    = copi_sync[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_q;
   assign ncs_rise  = ncs_s & ~ncs_q;
   assign ncs_fall  = ~ncs_s & ncs_q;

   // ncs chain resets to the idle (high) level so leaving reset never looks like a frame start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync <= '0;
         copi_sync <= '0;
         ncs_sync  <= '1;
         sclk_q    <= 1'b0;
         ncs_q     <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
         copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
         ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
         sclk_q    <= sclk_s;
         ncs_q     <= ncs_s;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_reg <= '0;
         bit_cnt   <= '0;
      end else if (ncs_fall) begin
         shift_reg <= '0;
         bit_cnt   <= '0;
      end else if (sclk_rise && !ncs_s) begin
         shift_reg <= {shift_reg[14:0], copi_s};
         if (bit_cnt != 5'd17)
            bit_cnt <= bit_cnt + 5'd1;
      end
   end

   // Commit is staged one cycle after the nCS rise; shift_reg is frozen while nCS is high
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_pend         <= 1'b0;
         en_reg_out_7_0  <= '0;
         en_reg_out_15_8 <= '0;
         en_reg_pwm_7_0  <= '0;
         en_reg_pwm_15_8 <= '0;
         pwm_duty_cycle  <= '0;
      end else begin
         wr_pend <= ncs_rise && (bit_cnt == 5'd16) && shift_reg[15]
                    && (shift_reg[14:8] <= MAX_ADDR);
         if (wr_pend) begin
            case (shift_reg[14:8])
               7'h00:   en_reg_out_7_0  <= shift_reg[7:0];
               7'h01:   en_reg_out_15_8 <= shift_reg[7:0];
               7'h02:   en_reg_pwm_7_0  <= shift_reg[7:0];
               7'h03:   en_reg_pwm_15_8 <= shift_reg[7:0];
               7'h04:   pwm_duty_cycle  <= shift_reg[7:0];
               default: ;
            endcase
         end
      end
   end

`ifdef SPI_READBACK_EN
   logic       rd_pend;
   logic [7:0] out_shift;
   logic [7:0] rd_data;
   logic       sclk_fall;

   assign sclk_fall = ~sclk_s & sclk_q;

   always_comb begin
      rd_data = 8'h00;
      if (shift_reg[6:0] <= MAX_ADDR) begin
         case (shift_reg[6:0])
            7'h00:   rd_data = en_reg_out_7_0;
            7'h01:   rd_data = en_reg_out_15_8;
            7'h02:   rd_data = en_reg_pwm_7_0;
            7'h03:   rd_data = en_reg_pwm_15_8;
            7'h04:   rd_data = pwm_duty_cycle;
            default: rd_data = 8'h00;
         endcase
      end
   end

   // First falling edge after the 8th rise is skipped so the MSB is seen on the 9th rise
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_pend   <= 1'b0;
         out_shift <= '0;
      end else begin
         rd_pend <= sclk_rise && !ncs_s && !ncs_fall && (bit_cnt == 5'd7);
         if (ncs_s || ncs_fall)
            out_shift <= '0;
         else if (rd_pend && !shift_reg[7])
            out_shift <= rd_data;
         else if (sclk_fall && (bit_cnt >= 5'd9))
            out_shift <= {out_shift[6:0], 1'b0};
      end
   end

   assign cipo = out_shift[7];
`else
   assign cipo = 1'b0;
`endif

endmodule
